// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: machine word and the RAM handshake state.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter_pkg.sv
// Arbiter-local types and sizing helpers.
package mem_arbiter_pkg;

    localparam int unsigned CPUS_DEF = 2;
    localparam int unsigned NREQ_DEF = 2 * CPUS_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Requester count: one D-port and one I-port per core.
    function automatic int unsigned nreq_of(input int unsigned cpus);
        return 2 * cpus;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational cyclic priority encoder: first set request at or after i_ptr.
module rr_picker #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_grant_idx_c,
    output logic          o_valid_c
);

    int unsigned w_idx;

    always_comb begin
        o_grant_idx_c = '0;
        o_valid_c     = 1'b0;
        w_idx         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = (32'(i_ptr) + i) % N;
            if (!o_valid_c && i_req[w_idx]) begin
                o_valid_c     = 1'b1;
                o_grant_idx_c = PW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-core RAM arbiter with registered round-robin grant held across RAM accesses.
// Optional MEM_ARB_DPRIO_EN: D-ports beat I-ports, separate round-robin per set.
module mem_arbiter
    import cpu_types_pkg::*;
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned CPUS = 2,
    parameter int unsigned AW   = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS*AW-1:0]   iaddr,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS*AW-1:0]   iload,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*AW-1:0]   daddr,
    input  logic [CPUS*AW-1:0]   dstore,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*AW-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [AW-1:0]        ramaddr,
    output logic [AW-1:0]        ramstore,
    input  logic [AW-1:0]        ramload,
    input  ramstate_t            ramstate,
    output logic                 busy
);

    localparam int unsigned NREQ = nreq_of(CPUS);
    localparam int unsigned PW   = $clog2(NREQ);
    localparam int unsigned CW   = (CPUS > 1) ? $clog2(CPUS) : 1;

    arb_state_t      r_state, w_state_nxt;
    logic [PW-1:0]   r_gnt, w_gnt_nxt;
    logic [NREQ-1:0] w_req;
    logic [PW-1:0]   w_win;
    logic            w_win_valid;
    logic            w_gnt_is_d;
    logic [CW-1:0]   w_gnt_core;
    logic            w_access;

    // Requester vector: even index = D-port, odd index = I-port of core r/2.
    always_comb begin
        w_req = '0;
        for (int unsigned c = 0; c < CPUS; c++) begin
            w_req[2*c]   = dREN[c] | dWEN[c];
            w_req[2*c+1] = iREN[c];
        end
    end

    assign w_gnt_is_d = ~r_gnt[0];
    assign w_gnt_core = CW'(r_gnt >> 1);
    assign w_access   = (r_state == GRANT) && w_req[r_gnt] && (ramstate == ACCESS);

`ifdef MEM_ARB_DPRIO_EN
    logic [CW-1:0]   r_dptr, r_iptr, w_dptr_nxt, w_iptr_nxt;
    logic [CPUS-1:0] w_dreq, w_ireq;
    logic [CW-1:0]   w_d_idx, w_i_idx;
    logic            w_d_valid, w_i_valid;

    always_comb begin
        w_dreq = '0;
        w_ireq = '0;
        for (int unsigned c = 0; c < CPUS; c++) begin
            w_dreq[c] = w_req[2*c];
            w_ireq[c] = w_req[2*c+1];
        end
    end

    rr_picker #(.N(CPUS)) u_dpick (
        .i_req         (w_dreq),
        .i_ptr         (r_dptr),
        .o_grant_idx_c (w_d_idx),
        .o_valid_c     (w_d_valid)
    );

    rr_picker #(.N(CPUS)) u_ipick (
        .i_req         (w_ireq),
        .i_ptr         (r_iptr),
        .o_grant_idx_c (w_i_idx),
        .o_valid_c     (w_i_valid)
    );

    assign w_win       = w_d_valid ? PW'({w_d_idx, 1'b0}) : PW'({w_i_idx, 1'b1});
    assign w_win_valid = w_d_valid | w_i_valid;

    // Only the pointer of the set that just completed advances.
    always_comb begin
        w_dptr_nxt = r_dptr;
        w_iptr_nxt = r_iptr;
        if (w_access) begin
            if (w_gnt_is_d) begin
                w_dptr_nxt = (w_gnt_core == CW'(CPUS-1)) ? '0 : w_gnt_core + CW'(1);
            end else begin
                w_iptr_nxt = (w_gnt_core == CW'(CPUS-1)) ? '0 : w_gnt_core + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dptr <= '0;
            r_iptr <= '0;
        end else begin
            r_dptr <= w_dptr_nxt;
            r_iptr <= w_iptr_nxt;
        end
    end
`else
    logic [PW-1:0] r_rr_ptr, w_rr_ptr_nxt;

    rr_picker #(.N(NREQ)) u_pick (
        .i_req         (w_req),
        .i_ptr         (r_rr_ptr),
        .o_grant_idx_c (w_win),
        .o_valid_c     (w_win_valid)
    );

    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_access) begin
            w_rr_ptr_nxt = (r_gnt == PW'(NREQ-1)) ? '0 : r_gnt + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end
`endif

    // Next-state: grant is latched in IDLE and held until ACCESS or withdrawal.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_win;
                end
            end
            GRANT: begin
                if (!w_req[r_gnt] || (ramstate == ACCESS)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    // RAM port follows the granted requester's live inputs; only its wait can drop.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        if ((r_state == GRANT) && w_req[r_gnt]) begin
            if (w_gnt_is_d) begin
                ramWEN   = dWEN[w_gnt_core];
                ramREN   = dREN[w_gnt_core] & ~dWEN[w_gnt_core];
                ramaddr  = daddr[w_gnt_core*AW +: AW];
                ramstore = dstore[w_gnt_core*AW +: AW];
            end else begin
                ramREN   = 1'b1;
                ramaddr  = iaddr[w_gnt_core*AW +: AW];
            end
            if (ramstate == ACCESS) begin
                if (w_gnt_is_d) begin
                    dwait[w_gnt_core] = 1'b0;
                end else begin
                    iwait[w_gnt_core] = 1'b0;
                end
            end
        end
    end

    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};
    assign busy  = (r_state == GRANT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions queued at issue, checked by a monitor.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned CPUS = 2;
    localparam int unsigned AW   = 32;
    localparam logic [31:0] LOAD_KEY = 32'h5A5A_0000;

    logic               CLK = 1'b0;
    logic               RST;
    logic [CPUS-1:0]    iREN, dREN, dWEN, iwait, dwait;
    logic [CPUS*AW-1:0] iaddr, daddr, dstore, iload, dload;
    logic               ramREN, ramWEN, busy;
    logic [AW-1:0]      ramaddr, ramstore, ramload;
    ramstate_t          ramstate;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] store;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt[4];
    int   seen[4];
    int   lat = 2;
    int   cnt_r = 0;
    bit   auto_drop = 1'b1;

    mem_arbiter #(.CPUS(CPUS), .AW(AW)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // RAM model: ACCESS after `lat` BUSY cycles of continuous enable.
    always @(negedge CLK) begin
        if (ramREN === 1'b1 || ramWEN === 1'b1) begin
            if (cnt_r >= lat) begin
                ramstate = ACCESS;
                cnt_r    = 0;
            end else begin
                ramstate = BUSY;
                cnt_r++;
            end
        end else begin
            ramstate = FREE;
            cnt_r    = 0;
        end
        ramload = ramaddr ^ LOAD_KEY;
    end

    // Monitor: every released wait must match the head of the scoreboard.
    always @(negedge CLK) begin
        int   n;
        int   r;
        exp_t e;
        #2;
        assert (!(|(dREN & dWEN))) else $error("dREN and dWEN asserted together");
        n = 0;
        r = 0;
        for (int c = 0; c < CPUS; c++) begin
            if (dwait[c] === 1'b0) begin n++; r = 2*c;   end
            if (iwait[c] === 1'b0) begin n++; r = 2*c+1; end
        end
        if (n > 0) begin
            done_cnt[r]++;
            chk("single_completion", n, 1);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_completion requester=%0d addr=0x%08h", r, ramaddr);
            end else begin
                e = q.pop_front();
                chk("grant_idx", r, e.idx);
                chk("ramaddr", ramaddr, e.addr);
                chk("ramWEN", {31'b0, ramWEN}, {31'b0, e.wen});
                chk("ramREN", {31'b0, ramREN}, {31'b0, !e.wen});
                if (e.wen) chk("ramstore", ramstore, e.store);
                else if (r % 2 == 1) chk("iload_lane", iload[(r/2)*AW +: AW], e.addr ^ LOAD_KEY);
                else chk("dload_lane", dload[(r/2)*AW +: AW], e.addr ^ LOAD_KEY);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int idx, input logic [31:0] addr, input logic wen, input logic [31:0] store);
        exp_t e;
        e.idx = idx; e.addr = addr; e.wen = wen; e.store = store;
        q.push_back(e);
    endtask

    task automatic drop(input int r);
        if (r % 2 == 1) iREN[r/2] = 1'b0;
        else begin dREN[r/2] = 1'b0; dWEN[r/2] = 1'b0; end
    endtask

    task automatic sync_done();
        for (int r = 0; r < 4; r++) begin
            if (done_cnt[r] != seen[r]) begin
                seen[r] = done_cnt[r];
                if (auto_drop) drop(r);
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            tick();
            sync_done();
            k++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        sync_done();
    endtask

    initial begin
        int b0, b1, b2, b3;
        for (int r = 0; r < 4; r++) begin done_cnt[r] = 0; seen[r] = 0; end
        iaddr = '0; daddr = '0; dstore = '0; dWEN = '0;

        // Reset held two cycles with every port requesting.
        RST = 1'b1; iREN = 2'b11; dREN = 2'b11;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_iwait", {30'b0, iwait}, 32'd3);
            chk("rst_dwait", {30'b0, dwait}, 32'd3);
            chk("rst_ramREN", {31'b0, ramREN}, 32'd0);
            chk("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
        end
        iREN = '0; dREN = '0; RST = 1'b0;
        tick();

        // Single I0 read: grant visible the next cycle, one wait pulse.
        iaddr[0 +: AW] = 32'h100;
        push(1, 32'h100, 1'b0, 32'h0);
        b1 = done_cnt[1];
        iREN[0] = 1'b1;
        tick();
        chk("read_busy", {31'b0, busy}, 32'd1);
        chk("read_ramREN", {31'b0, ramREN}, 32'd1);
        chk("read_ramaddr", ramaddr, 32'h100);
        chk("read_iwait_held", {30'b0, iwait}, 32'd3);
        wait_drain(20);
        repeat (3) begin tick(); sync_done(); end
        chk("read_iwait_pulses", done_cnt[1] - b1, 1);

        // Round-robin over all four continuously requesting ports.
        do_reset();
        auto_drop = 1'b0;
        daddr[0 +: AW] = 32'h1000; iaddr[0 +: AW] = 32'h1100;
        daddr[AW +: AW] = 32'h1200; iaddr[AW +: AW] = 32'h1300;
        push(0, 32'h1000, 1'b0, 0); push(1, 32'h1100, 1'b0, 0);
        push(2, 32'h1200, 1'b0, 0); push(3, 32'h1300, 1'b0, 0);
        push(0, 32'h1000, 1'b0, 0);
        b0 = done_cnt[0]; b1 = done_cnt[1]; b2 = done_cnt[2]; b3 = done_cnt[3];
        dREN = 2'b11; iREN = 2'b11;
        wait_drain(60);
        dREN = '0; iREN = '0;
        auto_drop = 1'b1;
        repeat (4) begin tick(); sync_done(); end
        chk("rr_d0_count", done_cnt[0] - b0, 2);
        chk("rr_i0_count", done_cnt[1] - b1, 1);
        chk("rr_d1_count", done_cnt[2] - b2, 1);
        chk("rr_i1_count", done_cnt[3] - b3, 1);

        // D1 write: write enables held until ACCESS.
        daddr[AW +: AW] = 32'h200; dstore[AW +: AW] = 32'hDEADBEEF;
        push(2, 32'h200, 1'b1, 32'hDEADBEEF);
        dWEN[1] = 1'b1;
        tick();
        chk("wr_ramWEN", {31'b0, ramWEN}, 32'd1);
        chk("wr_ramREN", {31'b0, ramREN}, 32'd0);
        chk("wr_ramstore", ramstore, 32'hDEADBEEF);
        chk("wr_ramaddr", ramaddr, 32'h200);
        chk("wr_dwait_held", {30'b0, dwait}, 32'd3);
        tick();
        chk("wr_ramWEN_hold", {31'b0, ramWEN}, 32'd1);
        wait_drain(20);

        // Withdrawal in BUSY leaves the pointer alone (pointer 1 after D0).
        lat = 6;
        do_reset();
        daddr[0 +: AW] = 32'h300;
        push(0, 32'h300, 1'b0, 0);
        dREN[0] = 1'b1;
        wait_drain(30);
        iaddr[AW +: AW] = 32'h310;
        iREN[1] = 1'b1;
        tick(); tick();
        chk("wd_busy", {31'b0, busy}, 32'd1);
        chk("wd_ramaddr", ramaddr, 32'h310);
        iREN[1] = 1'b0;
        tick();
        chk("wd_idle_busy", {31'b0, busy}, 32'd0);
        chk("wd_idle_ramREN", {31'b0, ramREN}, 32'd0);
        chk("wd_iwait", {30'b0, iwait}, 32'd3);
        daddr[0 +: AW] = 32'h320; daddr[AW +: AW] = 32'h330;
        push(2, 32'h330, 1'b0, 0);
        push(0, 32'h320, 1'b0, 0);
        dREN = 2'b11;
        wait_drain(60);

        // Reset mid-access: enables drop and the pointer returns to 0.
        iaddr[0 +: AW] = 32'h340;
        iREN[0] = 1'b1;
        tick(); tick();
        chk("rstmid_busy", {31'b0, busy}, 32'd1);
        RST = 1'b1; iREN[0] = 1'b0;
        tick();
        RST = 1'b0;
        chk("rstmid_busy_clr", {31'b0, busy}, 32'd0);
        chk("rstmid_ramREN", {31'b0, ramREN}, 32'd0);
        chk("rstmid_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("rstmid_iwait", {30'b0, iwait}, 32'd3);
        daddr[0 +: AW] = 32'h350; iaddr[AW +: AW] = 32'h360;
        push(0, 32'h350, 1'b0, 0);
        push(3, 32'h360, 1'b0, 0);
        dREN[0] = 1'b1; iREN[1] = 1'b1;
        wait_drain(60);
        lat = 2;

        // Mixed D/I request set from pointer 0.
        do_reset();
        iaddr[0 +: AW] = 32'h400; iaddr[AW +: AW] = 32'h410; daddr[AW +: AW] = 32'h420;
`ifdef MEM_ARB_DPRIO_EN
        push(2, 32'h420, 1'b0, 0);
        push(1, 32'h400, 1'b0, 0);
        push(3, 32'h410, 1'b0, 0);
`else
        push(1, 32'h400, 1'b0, 0);
        push(2, 32'h420, 1'b0, 0);
        push(3, 32'h410, 1'b0, 0);
`endif
        iREN = 2'b11; dREN[1] = 1'b1;
        wait_drain(40);
        repeat (4) begin tick(); sync_done(); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
